// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and sizing helpers for the bit-serial adder
//
// Purpose: FSM state encoding and bit-counter width helper used by the
//          serial adder controller.
// Ports:   none (package).

package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width for a WIDTH-bit serial operation. The counter only
    // needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice; floor at 1 bit.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - combinational 1-bit full adder
//
// Purpose: single full-adder cell reused every cycle by the serial adder.
// Ports:
//   a, b   operand bits
//   cin    carry in
//   sum    sum bit
//   carry  carry out

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic half;

    assign half  = a ^ b;
    assign sum   = half ^ cin;
    assign carry = (a & b) | (cin & half);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder controller
//
// Purpose: adds two WIDTH-bit operands plus carry-in LSB-first, one bit per
//          cycle through a single fa_cell, and presents the result with a
//          one-cycle done pulse.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    request, sampled only in IDLE
//   abort    cancel in-flight add, sampled only in RUN
//   a_in     operand A, captured on accepted start
//   b_in     operand B, captured on accepted start
//   cin_in   carry-in, captured on accepted start
//   busy     high in RUN and DONE
//   done     one-cycle pulse when sum_out/cout are freshly valid
//   sum_out  last completed sum, held until the next completion
//   cout     carry-out of the last completed sum

module serial_adder_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int               CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   s_sh;
    logic               c_reg;
    logic [CNT_W-1:0]   cnt;

    logic               fa_sum;
    logic               fa_carry;
    logic [WIDTH-1:0]   s_next;

    fa_cell u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (c_reg),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Sum bits enter from the MSB side so after WIDTH shifts bit 0 of the
    // result has landed in s_sh[0]. s_next is also the value committed to
    // sum_out on the final bit, so the last bit never needs an extra cycle.
    assign s_next = {fa_sum, s_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            c_reg   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        c_reg <= cin_in;
                        s_sh  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    // abort wins over the final-bit commit; results stay untouched
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        s_sh  <= s_next;
                        c_reg <= fa_carry;
                        cnt   <= cnt + ONE;
                        if (cnt == LAST) begin
                            sum_out <= s_next;
                            cout    <= fa_carry;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl

module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic prev_done = 1'b0;

    logic [W:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin_in  (cin_in),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int unsigned total;
        total = int'(a) + int'(b) + int'(c);
        return (W+1)'(total);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got result 0x%0h expected no done pulse", {cout, sum_out});
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({cout, sum_out} !== e) begin
                    errors++;
                    $display("FAIL result: got 0x%0h expected 0x%0h", {cout, sum_out}, e);
                end
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_done: got %0b expected 1", busy);
            end
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: got done high 2 cycles expected 1");
            end
        end
        prev_done = rst ? 1'b0 : done;
    end

    // Issue one add and wait for its done pulse; optionally check latency.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit check_lat);
        int lat;
        @(negedge clk);
        a_in = a; b_in = b; cin_in = c; start = 1'b1;
        exp_q.push_back(ref_add(a, b, c));
        @(posedge clk); #1;
        start = 1'b0;
        if (check_lat) chk("busy_after_start", busy, 1);
        lat = 0;
        while (done !== 1'b1 && lat < W + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) chk("done_timeout", 0, 1);
        else if (check_lat) chk("latency", lat, W);
        @(posedge clk); #1;
        if (check_lat) begin
            chk("done_cleared", done, 0);
            chk("busy_cleared", busy, 0);
        end
    endtask

    initial begin
        int d0;

        // Reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed adds
        run_add(8'h5A, 8'h3C, 1'b0, 1);
        chk("sum_5a_3c", {cout, sum_out}, 9'h096);
        run_add(8'hFF, 8'h01, 1'b0, 1);
        chk("sum_ff_01", {cout, sum_out}, 9'h100);
        run_add(8'hFF, 8'hFF, 1'b1, 1);
        chk("sum_ff_ff_1", {cout, sum_out}, 9'h1FF);

        // start held high with new operands during RUN is ignored
        d0 = done_count;
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0; start = 1'b1;
        exp_q.push_back(ref_add(8'h12, 8'h34, 1'b0));
        @(posedge clk); #1;
        a_in = 8'hAA; b_in = 8'h55;
        repeat (W) @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("hold_start_dones", done_count - d0, 1);
        chk("hold_start_sum", {cout, sum_out}, 9'h046);
        chk("hold_start_idle", busy, 0);

        // Abort on 4th RUN cycle keeps previous result
        run_add(8'hFF, 8'hFF, 1'b1, 0);
        d0 = done_count;
        @(negedge clk);
        a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        repeat (W + 3) @(posedge clk);
        #1;
        chk("abort_no_done", done_count - d0, 0);
        chk("abort_keep", {cout, sum_out}, 9'h1FF);
        run_add(8'h01, 8'h01, 1'b0, 1);
        chk("after_abort", {cout, sum_out}, 9'h002);

        // Abort coinciding with the final bit still suppresses completion
        d0 = done_count;
        @(negedge clk);
        a_in = 8'h80; b_in = 8'h80; cin_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (W - 1) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_last_no_done", done_count - d0, 0);
        chk("abort_last_keep", {cout, sum_out}, 9'h002);

        // Reset during RUN (cnt=5) clears everything immediately
        d0 = done_count;
        @(negedge clk);
        a_in = 8'h77; b_in = 8'h11; cin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        chk("midrun_rst_sum", {cout, sum_out}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;
        chk("midrun_rst_no_done", done_count - d0, 0);
        chk("midrun_rst_idle", busy, 0);

        // Randomized operand sets
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_add(ra, rb, rc, (i % 100) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
